// File: rtl/parity_tx_ctrl.sv
// parity_tx_ctrl: serial transmitter framing one byte as start, 8 data bits LSB first, parity, stop
// Ports: clk (rising-edge clock), rst_n (async active-low reset), in_data/in_valid (byte offer),
//        in_ready (accepting, IDLE only), tx (registered serial line, idle high),
//        busy (frame in progress), done (one-cycle pulse in the last STOP cycle)
module parity_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  // done is registered, so it is raised one cycle early to land in the final STOP cycle
  localparam logic [15:0] PEN  = 16'(CLKS_PER_BIT - 2);
  localparam logic        ODD  = (ODD_PARITY != 0);
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_par, r_tx, r_busy, r_ready, r_done;
  logic        w_tick;
  assign w_tick   = (r_cnt == LAST);
  assign in_ready = r_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE) r_cnt <= w_tick ? '0 : r_cnt + 16'd1;
      case (r_state)
        IDLE: if (in_valid && r_ready) begin
          r_data  <= in_data;
          r_par   <= ^in_data ^ ODD;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_tx    <= r_data[0];
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          if (r_idx == 3'd7) begin
            r_tx    <= r_par;
            r_state <= PARITY;
          end else begin
            r_tx  <= r_data[r_idx + 3'd1];
            r_idx <= r_idx + 3'd1;
          end
        end
        PARITY: if (w_tick) begin
          r_tx    <= 1'b1;
          r_state <= STOP;
        end
        STOP: begin
          r_done <= (r_cnt == PEN);
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_parity_tx_ctrl.sv
// tb_parity_tx_ctrl: directed and random frames on three parity_tx_ctrl configurations
module tb_parity_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [2:0] w_v, w_rdy, w_tx, w_bsy, w_dn;
  int         sel = 0;
  int         ncmp = 0;
  int         nfail = 0;
  always #5 clk = ~clk;
  assign w_v = in_valid ? 3'(1 << sel) : 3'b000;
  parity_tx_ctrl #(.CLKS_PER_BIT(4), .ODD_PARITY(0)) u_even4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(w_v[0]),
    .in_ready(w_rdy[0]), .tx(w_tx[0]), .busy(w_bsy[0]), .done(w_dn[0]));
  parity_tx_ctrl #(.CLKS_PER_BIT(4), .ODD_PARITY(1)) u_odd4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(w_v[1]),
    .in_ready(w_rdy[1]), .tx(w_tx[1]), .busy(w_bsy[1]), .done(w_dn[1]));
  parity_tx_ctrl #(.CLKS_PER_BIT(2), .ODD_PARITY(0)) u_even2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(w_v[2]),
    .in_ready(w_rdy[2]), .tx(w_tx[2]), .busy(w_bsy[2]), .done(w_dn[2]));
  function automatic int cpb_of(input int s);
    return (s == 2) ? 2 : 4;
  endfunction
  function automatic int odd_of(input int s);
    return (s == 1) ? 1 : 0;
  endfunction
  // reference frame: slot 0 start, slots 1..8 data LSB first, slot 9 parity, slot 10 stop
  function automatic logic exp_tx(input logic [7:0] b, input int k, input int s);
    int j;
    j = (k - 1) / cpb_of(s);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9) return (($countones(b) + odd_of(s)) % 2) == 1;
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s inst=%0d t=%0t observed=%b expected=%b", tag, sel, $time, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, w_tx[sel], 1'b1);
    chk({tag, "_ready"}, w_rdy[sel], 1'b1);
    chk({tag, "_busy"}, w_bsy[sel], 1'b0);
    chk({tag, "_done"}, w_dn[sel], 1'b0);
  endtask
  // called just after a negedge with the selected instance idle; returns just after a negedge
  task automatic frame(input logic [7:0] b, input bit keep, input logic [7:0] nxt,
                       input bit glitch, input int abort_k);
    int c;
    c = cpb_of(sel);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11 * c; k++) begin
      @(negedge clk);
      chk($sformatf("tx_%02h_k%0d", b, k), w_tx[sel], exp_tx(b, k, sel));
      chk($sformatf("done_k%0d", k), w_dn[sel], k == 11 * c);
      chk("busy", w_bsy[sel], 1'b1);
      chk("in_ready", w_rdy[sel], 1'b0);
      if (k == abort_k) begin
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx", w_tx[sel], 1'b1);
        chk("abort_busy", w_bsy[sel], 1'b0);
        chk("abort_ready", w_rdy[sel], 1'b1);
        chk("abort_done", w_dn[sel], 1'b0);
        in_valid = 1'b0;
        return;
      end
      if (k == 1) begin
        if (keep) in_data = nxt;
        else in_valid = 1'b0;
      end
      if (glitch && k == 3 * c) begin
        in_valid = 1'b1;
        in_data  = ~b;
      end
      if (glitch && k == 3 * c + 1) begin
        in_valid = 1'b0;
        in_data  = b;
      end
    end
    @(negedge clk);
    chk_idle("gap");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      chk_idle("reset");
    end
    sel = 0;
    rst_n = 1'b1;
    frame(8'hA5, 1'b0, 8'h00, 1'b0, 0);
    frame(8'h01, 1'b0, 8'h00, 1'b0, 0);
    for (int i = 0; i < 3; i++) frame(8'($urandom), 1'b0, 8'h00, 1'b0, 0);
    frame(8'($urandom), 1'b0, 8'h00, 1'b1, 0);
    frame(8'h3C, 1'b1, 8'hC3, 1'b0, 0);
    frame(8'hC3, 1'b0, 8'h00, 1'b0, 0);
    frame(8'($urandom), 1'b0, 8'h00, 1'b0, 4 * 4 + 2);
    repeat (3) begin
      @(negedge clk);
      chk_idle("in_reset");
    end
    rst_n = 1'b1;
    frame(8'h55, 1'b0, 8'h00, 1'b0, 0);
    sel = 1;
    frame(8'h00, 1'b0, 8'h00, 1'b0, 0);
    frame(8'hFF, 1'b0, 8'h00, 1'b0, 0);
    frame(8'($urandom), 1'b0, 8'h00, 1'b0, 0);
    sel = 2;
    frame(8'h80, 1'b0, 8'h00, 1'b0, 0);
    for (int i = 0; i < 2; i++) frame(8'($urandom), 1'b0, 8'h00, 1'b1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/parity_tx_ctrl.md
PARITY_TX_CTRL -- requirements
Module: parity_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter ODD_PARITY, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8  byte to frame and transmit.
REQ-006 SHALL have port in_valid  input  1  in_data is offered this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive in_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-013 SHALL accept a byte on a rising edge where in_valid && in_ready; on that edge, SHALL latch in_data, latch parity = XOR of in_data[7:0] XOR ODD_PARITY, and go to START.
REQ-014 SHALL ignore in_valid and in_data outside IDLE; a latched byte SHALL NOT change mid-frame.
REQ-015 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, using a baud counter that restarts at every bit boundary.
REQ-016 SHALL drive tx = 0 in START, in_data bits LSB first (bit 0..7) in DATA, the latched parity bit in PARITY, and tx = 1 in STOP and IDLE.
REQ-017 SHALL use a 3-bit bit index in DATA; it SHALL advance on each bit boundary and leave DATA for PARITY after bit 7.
REQ-018 SHALL take a frame of exactly 11*CLKS_PER_BIT cycles of tx, starting the cycle after acceptance.
REQ-019 SHALL assert done for exactly one cycle: the last cycle of STOP.
REQ-020 SHALL return to IDLE on the edge after done; in_ready SHALL be 1 in the next cycle, giving a minimum gap of one idle cycle (tx = 1) between back-to-back frames.
REQ-021 SHALL keep tx glitch-free; tx SHALL be driven directly from a flop.

Reset
REQ-022 SHALL, while rst_n = 0, force: state IDLE, tx = 1, in_ready = 1, busy = 0, done = 0, baud counter 0, bit index 0, data and parity registers 0.
REQ-023 SHALL abort a frame on reset assertion mid-frame, with tx going to 1 immediately (asynchronously); no done pulse SHALL follow.
REQ-024 SHALL accept a byte on the first rising edge after rst_n deasserts if in_valid = 1.

Verification
REQ-025 SHALL cover: CLKS_PER_BIT=4, ODD_PARITY=0, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop), each bit held 4 cycles, done pulses once at cycle 44 after acceptance.
REQ-026 SHALL cover: ODD_PARITY=0, send 0x01 -> parity bit 1; ODD_PARITY=1, send 0x00 -> parity bit 1; ODD_PARITY=1, send 0xFF -> parity bit 1.
REQ-027 SHALL cover: in_valid held high continuously with bytes 0x3C then 0xC3 -> two complete frames, exactly one idle cycle with tx=1 and in_ready=1 between them, second frame parity 0.
REQ-028 SHALL cover: in_valid pulsed with a different byte during DATA -> ignored; transmitted frame matches the originally accepted byte.
REQ-029 SHALL cover: rst_n asserted during DATA bit 3 -> tx = 1 and busy = 0 with no clock edge needed, no done pulse; after release, a new byte 0x55 transmits correctly.
REQ-030 SHALL cover: CLKS_PER_BIT=2 (minimum), send 0x80 -> frame length 22 cycles and bit 7 = 1 sampled in the final DATA slot.
